mul_sequencer: RTL and testbench

Multi-cycle unsigned multiplier with its own sequencing FSM, sitting beside the ALU in the EX stage. It executes the instruction the control unit decodes with ALUOp `2'b11` (MUL). It freezes the pipeline with a stall signal while it iterates. It returns the low or high half of the product in the cycle the pipeline is released.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/mul_sequencer_if.sv | 18 +
 rtl/mul_shift_add_dp.sv | 72 +++++++
 rtl/mul_sequencer.sv | 86 ++++++++
 tb/tb_mul_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared EX-stage definitions: MUL ALUOp, multiplier FSM states, iteration count.
// MUL_RADIX4_EN selects 2 multiplier bits per step instead of 1.
package cpu_pkg;

    localparam logic [1:0] ALUOP_MUL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

`ifdef MUL_RADIX4_EN
    localparam int MUL_DIGIT_W = 2;
`else
    localparam int MUL_DIGIT_W = 1;
`endif

    function automatic int mul_iter(input int data_w);
        return data_w / MUL_DIGIT_W;
    endfunction

    function automatic int mul_cnt_w(input int data_w);
        return $clog2(mul_iter(data_w));
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// EX-stage multiplier request/response bundle; the pipeline drives master, the multiplier is slave.
// stall is the only backpressure: the pipeline holds start/operands while it is high.
interface mul_sequencer_if #(parameter int DATA_W = 64) ();
    logic              start;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              hi_sel;
    logic              flush;
    logic              stall;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (output start, op_a, op_b, hi_sel, flush,
                    input  stall, busy, done, result);
    modport slave  (input  start, op_a, op_b, hi_sel, flush,
                    output stall, busy, done, result);
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath; one digit per step (radix-4 when MUL_RADIX4_EN is defined).
// o_product is the accumulator value after the current step, so it is final during the last step.
module mul_shift_add_dp
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [DATA_W-1:0]   i_op_a,
    input  logic [DATA_W-1:0]   i_op_b,
    output logic [2*DATA_W-1:0] o_product
);
    localparam int AW = 2*DATA_W + 1;

    // {acc_hi[DATA_W:0], multiplier/product_lo[DATA_W-1:0]}
    logic [AW-1:0]     r_acc;
    logic [AW-1:0]     w_acc_nxt;
    logic [DATA_W-1:0] r_m;

`ifdef MUL_RADIX4_EN
    logic [DATA_W+1:0] r_m3;
    logic [DATA_W+1:0] w_addend;
    logic [DATA_W+1:0] w_sum;

    always_comb begin
        w_addend = '0;
        case (r_acc[1:0])
            2'd1:    w_addend = {2'b00, r_m};
            2'd2:    w_addend = {1'b0, r_m, 1'b0};
            2'd3:    w_addend = r_m3;
            default: w_addend = '0;
        endcase
        w_sum     = {1'b0, r_acc[AW-1:DATA_W]} + w_addend;
        w_acc_nxt = {1'b0, w_sum, r_acc[DATA_W-1:2]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m3 <= '0;
        end else if (i_load) begin
            r_m3 <= {2'b00, i_op_a} + {1'b0, i_op_a, 1'b0};
        end
    end
`else
    logic [DATA_W:0] w_addend;
    logic [DATA_W:0] w_sum;

    always_comb begin
        w_addend  = r_acc[0] ? {1'b0, r_m} : '0;
        w_sum     = r_acc[AW-1:DATA_W] + w_addend;
        w_acc_nxt = {1'b0, w_sum, r_acc[DATA_W-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_m   <= '0;
        end else if (i_load) begin
            r_acc <= {{(DATA_W+1){1'b0}}, i_op_b};
            r_m   <= i_op_a;
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_product = w_acc_nxt[2*DATA_W-1:0];

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned MUL for EX: stalls the pipeline ITER+1 cycles, then pulses done with result.
// Radix-4 iteration (ITER = DATA_W/2) when MUL_RADIX4_EN is defined; flush aborts from any state.
module mul_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    mul_sequencer_if.slave bus
);
    localparam int ITER  = mul_iter(DATA_W);
    localparam int CNT_W = mul_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

    mul_state_e          r_state;
    mul_state_e          w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_hi_sel;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_result;
    logic                w_accept;
    logic                w_step;
    logic                w_last;
    logic [2*DATA_W-1:0] w_product;

    assign w_accept = (r_state == ST_IDLE) & bus.start & ~bus.flush;
    assign w_step   = (r_state == ST_RUN) & ~bus.flush;
    assign w_last   = w_step & (r_cnt == '0);

    mul_shift_add_dp #(.DATA_W(DATA_W)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_step    (w_step),
        .i_op_a    (bus.op_a),
        .i_op_b    (bus.op_b),
        .o_product (w_product)
    );

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) w_next = ST_RUN;
                ST_RUN:  if (r_cnt == '0) w_next = ST_DONE;
                ST_DONE: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi_sel <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= w_last;
            if (w_accept) begin
                r_cnt    <= CNT_LOAD;
                r_hi_sel <= bus.hi_sel;
            end else if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_last) begin
                r_result <= r_hi_sel ? w_product[2*DATA_W-1:DATA_W] : w_product[DATA_W-1:0];
            end
        end
    end

    // DONE is deliberately excluded: EX/MEM must capture result in that cycle.
    assign bus.stall  = ~rst & ~bus.flush & (((r_state == ST_IDLE) & bus.start) | (r_state == ST_RUN));
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: timing checks per scenario, results via scoreboard queue.
// Works in both radix modes; ITER comes from cpu_pkg.
module tb_mul_sequencer;
    import cpu_pkg::*;

    localparam int DW   = 64;
    localparam int ITER = mul_iter(DW);

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [DW-1:0] exp_q[$];

    mul_sequencer_if #(.DATA_W(DW)) bus ();

    mul_sequencer #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: result=%h, no result expected", bus.result);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (bus.result !== e) begin
                    n_errors++;
                    $display("FAIL sb_result: got %h expected %h", bus.result, e);
                end
            end
        end
    end

    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic hi);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return hi ? p[2*DW-1:DW] : p[DW-1:0];
    endfunction

    // Drives one MUL starting in the current cycle and checks stall/busy/done timing.
    task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic hi,
                           input string nm);
        int stall_cnt, busy_cnt, done_off;
        stall_cnt = 0;
        busy_cnt  = 0;
        done_off  = -1;
        exp_q.push_back(model(a, b, hi));
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.hi_sel = hi;
        for (int off = 0; off < 4*ITER + 10 && done_off < 0; off++) begin
            @(negedge clk);
            if (bus.stall === 1'b1) stall_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) done_off = off;
            tick();
            bus.start = 1'b0;
        end
        n_checks++;
        if (done_off != ITER + 1) begin
            n_errors++;
            $display("FAIL %s_done_cycle: got t+%0d expected t+%0d (-1 = timeout)", nm, done_off, ITER+1);
        end
        n_checks++;
        if (stall_cnt != ITER + 1) begin
            n_errors++;
            $display("FAIL %s_stall_len: got %0d expected %0d", nm, stall_cnt, ITER+1);
        end
        n_checks++;
        if (busy_cnt != ITER + 1) begin
            n_errors++;
            $display("FAIL %s_busy_len: got %0d expected %0d", nm, busy_cnt, ITER+1);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_after_done: busy=%b done=%b expected 0 0", nm, bus.busy, bus.done);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.op_a = 64'd3;
        bus.op_b = 64'd3;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall: got %b expected 0", bus.stall);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy_done: got %b %b expected 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.result !== '0) begin
            n_errors++;
            $display("FAIL reset_result: got %h expected 0", bus.result);
        end
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_mul(64'd6, 64'd7, 1'b0, "basic");
        run_mul(64'h0000_0001_2345_6789, 64'h0000_00AB_CDEF_0123, 1'b1, "mixed_hi");
        run_mul(64'h8000_0000_0000_0001, 64'd5, 1'b0, "mixed_lo");
    endtask

    task automatic test_max();
        run_mul('1, '1, 1'b1, "max_hi");
        run_mul('1, '1, 1'b0, "max_lo");
    endtask

    task automatic test_flush();
        logic [DW-1:0] prev;
        prev = bus.result;
        bus.start = 1'b1;
        bus.op_a  = 64'd11;
        bus.op_b  = 64'd13;
        bus.hi_sel = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_stall: got %b expected 0", bus.stall);
        end
        tick();
        bus.flush = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.result !== prev) begin
            n_errors++;
            $display("FAIL flush_result_held: got %h expected %h", bus.result, prev);
        end
        run_mul(64'd100, 64'd200, 1'b0, "after_flush");
    endtask

    task automatic test_back_to_back();
        int d1, d2, ndone;
        logic stall_acc2;
        d1 = -1;
        d2 = -1;
        ndone = 0;
        stall_acc2 = 1'b0;
        exp_q.push_back(model(64'd3, 64'd5, 1'b0));
        exp_q.push_back(model(64'd4, 64'd4, 1'b0));
        bus.start  = 1'b1;
        bus.op_a   = 64'd3;
        bus.op_b   = 64'd5;
        bus.hi_sel = 1'b0;
        for (int off = 0; off < 6*ITER + 20 && ndone < 2; off++) begin
            @(negedge clk);
            if (off == ITER + 2) stall_acc2 = bus.stall;
            if (bus.done === 1'b1) begin
                if (ndone == 0) d1 = off; else d2 = off;
                ndone++;
            end
            tick();
            bus.op_a = 64'd4;
            bus.op_b = 64'd4;
            if (ndone == 2) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        n_checks++;
        if (d1 != ITER + 1) begin
            n_errors++;
            $display("FAIL b2b_done1: got t+%0d expected t+%0d", d1, ITER+1);
        end
        n_checks++;
        if (stall_acc2 !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second_accept_stall: got %b expected 1", stall_acc2);
        end
        n_checks++;
        if (d2 != 2*ITER + 3) begin
            n_errors++;
            $display("FAIL b2b_done2: got t+%0d expected t+%0d", d2, 2*ITER+3);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1;
        bus.op_a  = 64'd9;
        bus.op_b  = 64'd9;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_errors++;
            $display("FAIL rstrun_stall: got %b expected 0", bus.stall);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
            n_errors++;
            $display("FAIL rstrun_outputs: busy=%b done=%b result=%h expected 0 0 0",
                     bus.busy, bus.done, bus.result);
        end
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rstrun_no_accept: busy=%b expected 0", bus.busy);
        end
        tick();
        run_mul(64'd12, 64'd12, 1'b0, "after_rst");
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.hi_sel = 1'b0;
        bus.flush  = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        repeat (5) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d results outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
